// File: rtl/ks_limb_sequencer.sv
// ks_limb_sequencer
//   Multi-precision wrapper around a pipelined W-bit adder stage. It accepts an
//   N*W-bit operand pair, then issues it to the adder one limb at a time,
//   least-significant limb first. Each limb's sum/cout is sampled LAT cycles
//   after its issue cycle, and the carry is chained into the next limb. The
//   assembled result is then presented on a valid/ready handshake.
//
//   Ports
//     clk, rst_n            clock, async active-low reset
//     in_valid/in_ready     operand handshake
//     in_a, in_b, in_cin    N*W-bit operands and carry into limb 0
//     add_a, add_b, add_cin registered limb operands to the adder stage
//     add_sum, add_cout     adder stage result (LAT cycles after issue)
//     out_valid/out_ready   result handshake
//     out_sum, out_cout     assembled sum and carry out of the top limb
//     out_ovf               signed overflow (only with KS_LIMB_SEQ_OVF_EN)
//
//   Build option: define KS_LIMB_SEQ_OVF_EN to add the out_ovf port.
module ks_limb_sequencer #(
  parameter int W   = 64,
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  input  logic           in_cin,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W-1:0]   add_sum,
  input  logic           add_cout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_sum,
  output logic           out_cout
`ifdef KS_LIMB_SEQ_OVF_EN
  ,
  output logic           out_ovf
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nx;
  logic [N*W-1:0]  op_a, op_b;     // shifted right one limb per sample
  logic [N*W-1:0]  a_shr, b_shr;
  logic [N*W-1:0]  sum_nx;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;            // WAIT cycles elapsed, minus one
  logic            carry;
  logic            sample, last;

  // The limb being processed always sits at the bottom of op_a/op_b, so the
  // next limb is just the bottom of the shifted copy. The result is assembled
  // by shifting in from the top; after N samples it is in natural order.
  assign a_shr  = op_a >> W;
  assign b_shr  = op_b >> W;
  assign sample = (state == WAIT) && (cnt == CW'(LAT - 1));
  assign last   = (idx == IW'(N - 1));

  always_comb begin
    sum_nx = out_sum >> W;
    sum_nx[N*W-1 -: W] = add_sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = ISSUE;
      ISSUE:                  state_nx = WAIT;
      WAIT:    if (sample)    state_nx = last ? DONE : ISSUE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  assign out_cout = carry;

  // Datapath. add_* are loaded on the edge that enters ISSUE so the limb is
  // on the adder inputs during the ISSUE cycle and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      idx     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      out_sum <= '0;
`ifdef KS_LIMB_SEQ_OVF_EN
      out_ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a    <= in_a;
          op_b    <= in_b;
          carry   <= in_cin;
          idx     <= '0;
          add_a   <= in_a[W-1:0];
          add_b   <= in_b[W-1:0];
          add_cin <= in_cin;
        end
        ISSUE: cnt <= '0;
        WAIT: if (sample) begin
          out_sum <= sum_nx;
          carry   <= add_cout;
          if (last) begin
`ifdef KS_LIMB_SEQ_OVF_EN
            // op_a/op_b bottom limbs are now the top limbs of the operands
            out_ovf <= (op_a[W-1] == op_b[W-1]) && (add_sum[W-1] != op_a[W-1]);
`endif
          end else begin
            idx     <= idx + 1'b1;
            op_a    <= a_shr;
            op_b    <= b_shr;
            add_a   <= a_shr[W-1:0];
            add_b   <= b_shr[W-1:0];
            add_cin <= add_cout;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_limb_sequencer.sv
module tb_ks_limb_sequencer;
  localparam int W   = 64;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int NW  = N * W;
  localparam int EXP_LAT = N * (LAT + 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_cout, add_cin, add_cout;
  logic [NW-1:0] in_a = '0, in_b = '0, out_sum;
  logic [W-1:0]  add_a, add_b, add_sum;
  logic          ovf;

  always #5 clk = ~clk;

  ks_limb_sequencer #(.W(W), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef KS_LIMB_SEQ_OVF_EN
    , .out_ovf(ovf)
`endif
  );
`ifndef KS_LIMB_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif

  // Adder stage model: LAT-deep pipeline, free running, never reset.
  logic [W:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_sum  = pipe[LAT-1][W-1:0];
  assign add_cout = pipe[LAT-1][W];

  int ncmp = 0, nerr = 0;

  task automatic chk(input string nm, input logic [NW:0] act, input logic [NW:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"},  in_ready, 1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_sum"},   out_sum, 0);
    chk({tag, " out_cout"},  out_cout, 0);
    chk({tag, " add_a"},     add_a, 0);
    chk({tag, " add_b"},     add_b, 0);
    chk({tag, " add_cin"},   add_cin, 0);
`ifdef KS_LIMB_SEQ_OVF_EN
    chk({tag, " out_ovf"},   ovf, 0);
`endif
  endtask

  // Captured observations from the last run_op
  logic [N-1:0]  iss_cin;
  logic [W-1:0]  iss_a [N];
  logic [NW-1:0] got_sum;
  logic          got_cout, got_ovf;
  int            got_lat;

  // Offer one operand pair, watch it through, hold out_ready low for `hold`
  // cycles after out_valid, then complete the output handshake.
  task automatic run_op(input string nm, input logic [NW-1:0] a, b, input logic c, input int hold);
    int cyc, tmo;
    tmo = 0;
    @(negedge clk);
    while (!in_ready && tmo < 50) begin @(negedge clk); tmo++; end
    chk({nm, " in_ready before accept"}, in_ready, 1);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    cyc = 0; got_lat = -1; iss_cin = '0;
    while (cyc < 300) begin
      @(negedge clk); cyc++;
      for (int k = 0; k < N; k++)
        if (cyc == 1 + k * (LAT + 1)) begin iss_cin[k] = add_cin; iss_a[k] = add_a; end
      if (out_valid) begin got_lat = cyc; break; end
    end
    chk({nm, " out_valid latency"}, got_lat, EXP_LAT);
    got_sum = out_sum; got_cout = out_cout; got_ovf = ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " hold out_valid"}, out_valid, 1);
      chk({nm, " hold in_ready"},  in_ready, 0);
      chk({nm, " hold out_sum"},   {out_cout, out_sum}, {got_cout, got_sum});
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " post-handshake out_valid"}, out_valid, 0);
    chk({nm, " post-handshake in_ready"},  in_ready, 1);
  endtask

  typedef struct {
    string         nm;
    logic [NW-1:0] a, b;
    logic          cin;
    logic [NW-1:0] exp_sum;
    logic          exp_cout;
    logic          exp_ovf;
    logic [N-1:0]  exp_icin;   // add_cin seen at each limb's issue
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [NW-1:0] ones, maxpos, r_a, r_b, r_s, two55;
    logic [NW:0]   full;
    logic          r_c, r_o;
    ones   = '1;
    two55  = '0; two55[NW-1] = 1'b1;
    maxpos = ones >> 1;
    vecs[0] = '{"ripple",  ones,   NW'(1), 1'b0, '0,          1'b1, 1'b0, 4'b1110};
    vecs[1] = '{"cin",     '0,     '0,     1'b1, NW'(1),      1'b0, 1'b0, 4'b0001};
    vecs[2] = '{"ovf_pos", maxpos, NW'(1), 1'b0, two55,       1'b0, 1'b1, 4'b1110};
    vecs[3] = '{"small",   NW'(5), NW'(7), 1'b0, NW'(12),     1'b0, 1'b0, 4'b0000};
    vecs[4] = '{"h1234",   NW'(16'h1234), NW'(1), 1'b0, NW'(16'h1235), 1'b0, 1'b0, 4'b0000};

    // Reset state
    #1 chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    chk_reset_vals("reset held");
    rst_n = 1'b1;

    // Directed vectors; first one also exercises backpressure
    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].nm, vecs[v].a, vecs[v].b, vecs[v].cin, (v == 0) ? 5 : 0);
      chk({vecs[v].nm, " sum"},  got_sum,  vecs[v].exp_sum);
      chk({vecs[v].nm, " cout"}, got_cout, vecs[v].exp_cout);
      chk({vecs[v].nm, " issue cins"}, iss_cin, vecs[v].exp_icin);
      for (int k = 0; k < N; k++)
        chk({vecs[v].nm, " issue a limb"}, iss_a[k], vecs[v].a[k*W +: W]);
`ifdef KS_LIMB_SEQ_OVF_EN
      chk({vecs[v].nm, " ovf"}, got_ovf, vecs[v].exp_ovf);
`endif
    end

    // Reset in the middle of limb 2's WAIT
    @(negedge clk);
    in_a = ones; in_b = NW'(1); in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2 * (LAT + 1) + 2) @(negedge clk);
    chk("midrst in_ready before reset", in_ready, 0);
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk); rst_n = 1'b1;
    run_op("after reset", NW'(16'h1234), NW'(1), 1'b0, 1);
    chk("after reset sum",  got_sum,  NW'(16'h1235));
    chk("after reset cout", got_cout, 0);

    // Randomized operands against a plain-arithmetic reference
    for (int t = 0; t < 20; t++) begin
      for (int j = 0; j < NW / 32; j++) begin
        r_a[j*32 +: 32] = $urandom;
        r_b[j*32 +: 32] = $urandom;
      end
      if (t % 5 == 1) r_a = ones;               // long carry chains
      if (t % 5 == 2) r_b = ~r_a;
      r_c  = 1'($urandom_range(0, 1));
      full = {1'b0, r_a} + {1'b0, r_b} + (NW+1)'(r_c);
      r_s  = full[NW-1:0];
      r_o  = (r_a[NW-1] == r_b[NW-1]) && (r_s[NW-1] != r_a[NW-1]);
      run_op("rand", r_a, r_b, r_c, $urandom_range(0, 3));
      chk("rand sum",  got_sum,  r_s);
      chk("rand cout", got_cout, full[NW]);
`ifdef KS_LIMB_SEQ_OVF_EN
      chk("rand ovf",  got_ovf,  r_o);
`else
      if (r_o && got_ovf) $display("note: unreachable");
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
